// File: rtl/adc_avg_filter.sv
// Moving-average filter between the ADC receiver and the PID controller y input.
// Keeps a circular window of 2^N_LOG2 samples and publishes floor(sum / 2^N_LOG2).
module adc_avg_filter #(
   parameter int WIDTH  = 20,
   parameter int N_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clear,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             primed
);

   localparam int                DEPTH     = 1 << N_LOG2;
   localparam int                SW        = WIDTH + N_LOG2;
   localparam logic [N_LOG2:0]   FILL_LAST = (N_LOG2 + 1)'(DEPTH - 1);

   typedef enum logic {FILL, RUN} state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_buf [DEPTH];
   logic [N_LOG2-1:0] r_wr_ptr;
   logic [N_LOG2:0]   r_fill_cnt;
   logic [SW-1:0]     r_sum;
   logic [SW-1:0]     w_sum_new;

   // The outgoing entry is always part of r_sum, so the subtraction cannot underflow.
   assign w_sum_new = r_sum + SW'(in_data) - SW'(r_buf[r_wr_ptr]);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= FILL;
         r_wr_ptr   <= '0;
         r_fill_cnt <= '0;
         r_sum      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         primed     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      end else if (clear) begin
         // Flush history but keep the last published mean on out_data.
         r_state    <= FILL;
         r_wr_ptr   <= '0;
         r_fill_cnt <= '0;
         r_sum      <= '0;
         out_valid  <= 1'b0;
         primed     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid) begin
            r_sum           <= w_sum_new;
            r_buf[r_wr_ptr] <= in_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
            case (r_state)
               FILL: begin
                  r_fill_cnt <= r_fill_cnt + 1'b1;
                  if (r_fill_cnt == FILL_LAST) begin
                     r_state   <= RUN;
                     primed    <= 1'b1;
                     out_valid <= 1'b1;
                     out_data  <= w_sum_new[SW-1:N_LOG2];
                  end
               end
               RUN: begin
                  out_valid <= 1'b1;
                  out_data  <= w_sum_new[SW-1:N_LOG2];
               end
               default: r_state <= FILL;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_avg_filter.sv
// Bench for adc_avg_filter: per-cycle expectations from a sample-window model are
// queued by the driver and consumed by an independent output monitor.
module tb_adc_avg_filter;

   localparam int WIDTH  = 20;
   localparam int N_LOG2 = 2;
   localparam int DEPTH  = 1 << N_LOG2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             clear;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             primed;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic             vld;
      logic [WIDTH-1:0] data;
      logic             prim;
   } exp_t;

   exp_t             sb[$];
   int unsigned      win[$];
   logic [WIDTH-1:0] m_hold = '0;

   adc_avg_filter #(.WIDTH(WIDTH), .N_LOG2(N_LOG2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
      .out_valid(out_valid), .out_data(out_data), .primed(primed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Apply one cycle of inputs, then advance the window model for that edge.
   task automatic step(input logic v, input logic [WIDTH-1:0] d,
                       input logic c = 1'b0, input logic r = 1'b1);
      exp_t   e;
      longint s;
      in_valid = v; in_data = d; clear = c; rst = r;
      @(posedge clk);
      e.vld = 1'b0;
      if (!r) begin
         win.delete();
         m_hold = '0;
      end else if (c) begin
         win.delete();
      end else if (v) begin
         win.push_back(d);
         if (win.size() > DEPTH) void'(win.pop_front());
         if (win.size() == DEPTH) begin
            s = 0;
            foreach (win[i]) s += win[i];
            m_hold = WIDTH'(s / DEPTH);
            e.vld  = 1'b1;
         end
      end
      e.data = m_hold;
      e.prim = (win.size() == DEPTH);
      sb.push_back(e);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("sb_out_valid", out_valid, e.vld);
         chk("sb_out_data",  out_data,  e.data);
         chk("sb_primed",    primed,    e.prim);
      end
   end

   initial begin
      int unsigned d;
      int          wait_cnt;
      in_valid = 0; in_data = '0; clear = 0; rst = 0;

      // Reset state
      step(0, 0, 0, 0);
      step(1, 20'h12345, 0, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_primed", primed, 0);

      // Priming
      step(1, 100); chk("prime1_valid", out_valid, 0);
      step(1, 200); chk("prime2_valid", out_valid, 0);
      step(1, 300); chk("prime3_valid", out_valid, 0); chk("prime3_primed", primed, 0);
      step(0, 20'h55555);
      chk("idle_ignored_valid", out_valid, 0);
      step(1, 400);
      chk("prime4_valid", out_valid, 1);
      chk("prime4_data", out_data, 250);
      chk("prime4_primed", primed, 1);
      step(0, 0);
      chk("strobe_one_cycle", out_valid, 0);
      chk("hold_data", out_data, 250);

      // Steady state
      step(1, 800); chk("steady_800", out_data, 425);
      step(1, 0);   chk("steady_0", out_data, 375);

      // Full scale, back-to-back
      repeat (4) step(1, 20'hFFFFF);
      chk("full_scale", out_data, 20'hFFFFF);
      step(1, 0);
      chk("full_scale_drop", out_data, 20'hBFFFF);

      // Floor rounding
      step(1, 1); step(1, 1); step(1, 1); step(1, 2);
      chk("floor_round", out_data, 1);

      // Clear conflict with in_valid
      step(0, 0, 1);
      repeat (4) step(1, 1000);
      chk("clr_prime_data", out_data, 1000);
      step(1, 5, 1);
      chk("clr_primed", primed, 0);
      chk("clr_valid", out_valid, 0);
      chk("clr_hold", out_data, 1000);
      step(1, 8); step(1, 8); step(1, 8);
      chk("clr_refill_valid", out_valid, 0);
      step(1, 8);
      chk("clr_refill_out", out_data, 8);
      chk("clr_refill_primed", primed, 1);

      // Reset mid-operation
      step(1, 10); step(1, 20); step(1, 30); step(1, 40);
      step(1, 999, 0, 0);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_data", out_data, 0);
      chk("midrst_primed", primed, 0);
      step(1, 7); step(1, 9); step(1, 11);
      chk("midrst_fill_valid", out_valid, 0);
      step(1, 13);
      chk("midrst_mean", out_data, 10);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         d = $urandom;
         if ($urandom_range(0, 9) == 0) d = 32'hFFFFF;
         step(($urandom_range(0, 3) != 0), WIDTH'(d),
              ($urandom_range(0, 59) == 0), ($urandom_range(0, 249) != 0));
      end
      step(0, 0);

      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      if (sb.size() > 0) chk("sb_drain", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
